// File: rtl/rob_pkg.sv
// Reorder-buffer types and sizing shared by dispatch and the ROB itself.
package rob_pkg;
  localparam int ROB_ENTRIES        = 16;
  localparam int DISPATCH_BUF_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_DONE  = 2'd3
  } rob_status_e;

  typedef struct packed {
    rob_status_e status;
    logic [5:0]  dst_preg;
    logic [5:0]  old_preg;
    logic [15:0] pc;
  } rob_entry;
endpackage

// File: rtl/uop_pkg.sv
// Front-end micro-op constants shared by the rename and dispatch stages.
package uop_pkg;
  localparam int INSTR_Q_WIDTH = 2;
endpackage

// File: rtl/rob_dispatch_buffer.sv
// Decoupling FIFO between rename and ROB enqueue; moves up to Q_WIDTH entries per side per cycle.
// Optional stall perf counter enabled by defining DISPATCH_PERF_CNT_EN.
module rob_dispatch_buffer
  import rob_pkg::*;
#(
  parameter int Q_WIDTH   = uop_pkg::INSTR_Q_WIDTH,
  parameter int BUF_DEPTH = DISPATCH_BUF_DEPTH,
  parameter int ROB_DEPTH = ROB_ENTRIES
) (
  input  logic                               clk_in,
  input  logic                               rst_N_in,
  input  logic                               flush_in,
  input  rob_entry [Q_WIDTH-1:0]             ren_entries_in,
  input  logic [$clog2(Q_WIDTH+1)-1:0]       ren_count_in,
  output logic                               ren_ready_out,
  input  logic [$clog2(ROB_DEPTH)-1:0]       rob_size_in,
  output rob_entry [Q_WIDTH-1:0]             rob_entries_out,
  output logic [$clog2(Q_WIDTH+1)-1:0]       rob_enq_out,
`ifdef DISPATCH_PERF_CNT_EN
  output logic [$clog2(BUF_DEPTH+1)-1:0]     occupancy_out,
  output logic [31:0]                        stall_cycles_out
`else
  output logic [$clog2(BUF_DEPTH+1)-1:0]     occupancy_out
`endif
);

  localparam int CNT_W = $clog2(Q_WIDTH+1);
  localparam int OCC_W = $clog2(BUF_DEPTH+1);
  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  rob_entry         mem_q [BUF_DEPTH];
  rob_entry         mem_d [BUF_DEPTH];
  logic [CNT_W-1:0] enq, acc;
  logic             ready;

  always_comb begin : ctrl
    logic [31:0] free_w;
    logic [31:0] lim_w;
    ready = rst_N_in && !flush_in &&
            ((32'(BUF_DEPTH) - 32'(occ_q)) >= 32'(Q_WIDTH));
    // The ROB keeps one slot spare, so it is full at ROB_DEPTH-1 entries.
    if (32'(rob_size_in) >= 32'(ROB_DEPTH - 1)) free_w = '0;
    else free_w = 32'(ROB_DEPTH - 1) - 32'(rob_size_in);
    lim_w = 32'(occ_q);
    if (32'(Q_WIDTH) < lim_w) lim_w = 32'(Q_WIDTH);
    if (free_w < lim_w) lim_w = free_w;
    enq = (rst_N_in && !flush_in) ? CNT_W'(lim_w) : '0;
    acc = '0;
    if (ready) acc = (32'(ren_count_in) > 32'(Q_WIDTH)) ? CNT_W'(Q_WIDTH) : ren_count_in;
  end

  always_comb begin : wr_path
    rob_entry ent;
    ent   = '0;
    mem_d = mem_q;
    for (int i = 0; i < Q_WIDTH; i++) begin
      if (i < int'(acc)) begin
        ent        = ren_entries_in[i];
        ent.status = ST_READY;
        mem_d[tail_q + PTR_W'(i)] = ent;
      end
    end
  end

  always_comb begin : rd_path
    rob_entries_out = '0;
    for (int i = 0; i < Q_WIDTH; i++) begin
      if (i < int'(enq)) rob_entries_out[i] = mem_q[head_q + PTR_W'(i)];
    end
  end

  always_comb begin : ptr_next
    head_d = head_q + PTR_W'(enq);
    tail_d = tail_q + PTR_W'(acc);
    occ_d  = occ_q + OCC_W'(acc) - OCC_W'(enq);
    if (flush_in) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Entry storage is never reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((occ_q != '0) && (enq == '0) && !flush_in && (stall_q != '1))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) stall_q <= '0;
    else stall_q <= stall_d;
  end

  assign stall_cycles_out = stall_q;
`endif

  assign ren_ready_out = ready;
  assign rob_enq_out   = enq;
  assign occupancy_out = occ_q;

endmodule
